// File: rtl/lamp_fpu_exp2_if.sv
// lamp_fpu_exp2_if: operand/result bundle of the bfloat16 2^x unit.
// The master side drives the request and operand fields; the slave side returns the result.
interface lamp_fpu_exp2_if;
    logic       doExp_i;
    logic       s_op_i;
    logic [7:0] e_op_i;
    logic [6:0] f_op_i;
    logic       isZ_op_i;
    logic       isInf_op_i;
    logic       isSNAN_op_i;
    logic       isQNAN_op_i;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;
    logic       isOverflow_o;
    logic       isUnderflow_o;
    logic       isToRound_o;

    modport master (
        output doExp_i, s_op_i, e_op_i, f_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i,
        input  s_res_o, e_res_o, f_res_o, valid_o, isOverflow_o, isUnderflow_o, isToRound_o
    );

    modport slave (
        input  doExp_i, s_op_i, e_op_i, f_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i,
        output s_res_o, e_res_o, f_res_o, valid_o, isOverflow_o, isUnderflow_o, isToRound_o
    );
endinterface

// File: rtl/lamp_fpu_exp2.sv
// lamp_fpu_exp2: multi-cycle bfloat16 2^x, unrounded fields plus a round request.
// Define LAMP_EXP2_EARLY_EXIT_EN to leave ITER as soon as the remaining bits of r are zero.
module lamp_fpu_exp2 #(
    parameter int unsigned FRAC_W = 12,
    parameter int unsigned ACC_W  = 16
) (
    input logic            clk,
    input logic            rst,
    lamp_fpu_exp2_if.slave io_exp
);
    localparam int unsigned E_DW = 8;
    localparam int unsigned F_DW = 7;
    localparam int unsigned BIAS = 127;
    localparam int unsigned KW   = 5;
    localparam int unsigned XW   = F_DW + 1 + FRAC_W;
    localparam int unsigned WIDE = XW + F_DW;
    localparam int unsigned NW   = XW - FRAC_W + 1;

    localparam logic [E_DW-1:0]      E_ONE   = E_DW'(BIAS);
    localparam logic [E_DW-1:0]      E_MIN   = E_DW'(BIAS - FRAC_W);
    localparam logic [E_DW-1:0]      E_BIG   = E_DW'(BIAS + 7);
    localparam logic [F_DW-1:0]      F_QNAN  = {1'b1, {(F_DW-1){1'b0}}};
    localparam logic [ACC_W:0]       ACC_ONE = {1'b1, {ACC_W{1'b0}}};
    localparam logic signed [NW-1:0] N_MAX   = NW'(127);
    localparam logic signed [NW-1:0] N_MIN   = NW'(-126);
    localparam logic signed [NW-1:0] N_BIAS  = NW'(BIAS);

    typedef enum logic [2:0] {StIdle, StAlign, StIter, StNorm, StDone} state_t;

    // C[k] = 2^(2^-k) rounded to 16 fraction bits (table built for ACC_W = 16)
    function automatic logic [ACC_W:0] c_tab(input logic [KW-1:0] k);
        logic [16:0] c;
        case (k)
            5'd1:    c = 17'h16A0A;
            5'd2:    c = 17'h13070;
            5'd3:    c = 17'h1172C;
            5'd4:    c = 17'h10B56;
            5'd5:    c = 17'h1059B;
            5'd6:    c = 17'h102CA;
            5'd7:    c = 17'h10164;
            5'd8:    c = 17'h100B2;
            5'd9:    c = 17'h10059;
            5'd10:   c = 17'h1002C;
            5'd11:   c = 17'h10016;
            5'd12:   c = 17'h1000B;
            5'd13:   c = 17'h10006;
            5'd14:   c = 17'h10003;
            5'd15:   c = 17'h10001;
            5'd16:   c = 17'h10001;
            default: c = 17'h10000;
        endcase
        return (ACC_W+1)'(c);
    endfunction

    state_t          r_state;
    logic            r_s_op, r_is_z, r_is_inf, r_is_nan;
    logic [E_DW-1:0] r_e_op;
    logic [F_DW-1:0] r_f_op;
    logic [FRAC_W-1:0] r_r;
    logic [ACC_W:0]  r_acc;
    logic [KW-1:0]   r_k;
    logic [E_DW-1:0] r_st_e;
    logic [F_DW-1:0] r_st_f;
    logic            r_st_ovf, r_st_unf, r_st_rnd;
    logic            r_s_res, r_valid, r_ovf, r_unf, r_rnd;
    logic [E_DW-1:0] r_e_res;
    logic [F_DW-1:0] r_f_res;

    logic [E_DW-1:0]        w_sh;
    logic [WIDE-1:0]        w_wide;
    logic [XW-1:0]          w_mag;
    logic signed [XW:0]     w_x;
    logic signed [NW-1:0]   w_n;
    logic [FRAC_W-1:0]      w_r;
    logic [E_DW-1:0]        w_e_num;
    logic                   w_ovf, w_unf;
    logic [2*ACC_W+1:0]     w_prod;
    logic [ACC_W:0]         w_acc_mul;
    logic                   w_iter_last;
    logic                   w_guard, w_sticky;

    // X = 1.f scaled to FRAC_W fraction bits; bits shifted below the LSB are dropped
    always_comb begin
        w_sh      = r_e_op - E_MIN;
        w_wide    = {{(WIDE-F_DW-1){1'b0}}, 1'b1, r_f_op} << w_sh;
        w_mag     = XW'(w_wide >> F_DW);
        w_x       = r_s_op ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
        w_n       = w_x[XW:FRAC_W];
        w_r       = w_x[FRAC_W-1:0];
        w_e_num   = E_DW'(w_n + N_BIAS);
        w_ovf     = (r_e_op >= E_BIG) ? !r_s_op : (w_n > N_MAX);
        w_unf     = (r_e_op >= E_BIG) ? r_s_op : (w_n < N_MIN);
        w_prod    = r_acc * c_tab(r_k);
        w_acc_mul = (ACC_W+1)'(w_prod >> ACC_W);
        w_guard   = r_acc[ACC_W-F_DW-1];
        w_sticky  = |r_acc[ACC_W-F_DW-2:0];
    end

`ifdef LAMP_EXP2_EARLY_EXIT_EN
    assign w_iter_last = (r_r[FRAC_W-2:0] == '0);
`else
    assign w_iter_last = (r_k == KW'(FRAC_W));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_s_op   <= 1'b0;
            r_e_op   <= '0;
            r_f_op   <= '0;
            r_is_z   <= 1'b0;
            r_is_inf <= 1'b0;
            r_is_nan <= 1'b0;
            r_r      <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_st_e   <= '0;
            r_st_f   <= '0;
            r_st_ovf <= 1'b0;
            r_st_unf <= 1'b0;
            r_st_rnd <= 1'b0;
            r_s_res  <= 1'b0;
            r_e_res  <= '0;
            r_f_res  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_rnd    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_exp.doExp_i) begin
                        r_s_op   <= io_exp.s_op_i;
                        r_e_op   <= io_exp.e_op_i;
                        r_f_op   <= io_exp.f_op_i;
                        r_is_z   <= io_exp.isZ_op_i;
                        r_is_inf <= io_exp.isInf_op_i;
                        r_is_nan <= io_exp.isSNAN_op_i | io_exp.isQNAN_op_i;
                        r_state  <= StAlign;
                    end
                end
                StAlign: begin
                    r_st_f   <= '0;
                    r_st_ovf <= 1'b0;
                    r_st_unf <= 1'b0;
                    r_st_rnd <= 1'b0;
                    r_state  <= StDone;
                    if (r_is_nan) begin
                        r_st_e <= '1;
                        r_st_f <= F_QNAN;
                    end else if (r_is_inf) begin
                        r_st_e <= r_s_op ? '0 : '1;
                    end else if (r_is_z || (r_e_op < E_MIN)) begin
                        r_st_e <= E_ONE;
                    end else if (w_ovf) begin
                        r_st_e   <= '1;
                        r_st_ovf <= 1'b1;
                    end else if (w_unf) begin
                        r_st_e   <= '0;
                        r_st_unf <= 1'b1;
                    end else begin
                        r_st_e  <= w_e_num;
                        r_r     <= w_r;
                        r_acc   <= ACC_ONE;
                        r_k     <= KW'(1);
                        r_state <= StIter;
`ifdef LAMP_EXP2_EARLY_EXIT_EN
                        if (w_r == '0) r_state <= StNorm;
`endif
                    end
                end
                StIter: begin
                    if (r_r[FRAC_W-1]) r_acc <= w_acc_mul;
                    r_r <= r_r << 1;
                    r_k <= r_k + KW'(1);
                    if (w_iter_last) r_state <= StNorm;
                end
                StNorm: begin
                    // acc stays in [1,2): the fraction is read straight off the top bits
                    r_st_f   <= r_acc[ACC_W-1 -: F_DW];
                    r_st_rnd <= w_guard & (w_sticky | r_acc[ACC_W-F_DW]);
                    r_state  <= StDone;
                end
                StDone: begin
                    r_s_res <= 1'b0;
                    r_e_res <= r_st_e;
                    r_f_res <= r_st_f;
                    r_ovf   <= r_st_ovf;
                    r_unf   <= r_st_unf;
                    r_rnd   <= r_st_rnd;
                    r_valid <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_exp.s_res_o       = r_s_res;
    assign io_exp.e_res_o       = r_e_res;
    assign io_exp.f_res_o       = r_f_res;
    assign io_exp.valid_o       = r_valid;
    assign io_exp.isOverflow_o  = r_ovf;
    assign io_exp.isUnderflow_o = r_unf;
    assign io_exp.isToRound_o   = r_rnd;
endmodule

// File: tb/tb_lamp_fpu_exp2.sv
// tb_lamp_fpu_exp2: directed vectors for lamp_fpu_exp2 plus reset-abort, back-to-back
// and busy-input sequences.
module tb_lamp_fpu_exp2;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lamp_fpu_exp2_if u_if ();

    lamp_fpu_exp2 #(.FRAC_W(12), .ACC_W(16)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_exp (u_if.slave)
    );

    typedef struct {
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        logic [3:0] cls;   // {z, inf, snan, qnan}
        logic [7:0] xe;
        logic [6:0] xf;
        logic [2:0] xflg;  // {ovf, unf, rnd}
        int         lat;
        int         lat_early;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [6:0] f,
                                input logic [3:0] cls, input logic [7:0] xe,
                                input logic [6:0] xf, input logic [2:0] xflg,
                                input int lat, input int lat_early);
        vec_t v;
        v.s = s; v.e = e; v.f = f; v.cls = cls;
        v.xe = xe; v.xf = xf; v.xflg = xflg;
        v.lat = lat; v.lat_early = lat_early;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
`ifdef LAMP_EXP2_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        u_if.s_op_i      = v.s;
        u_if.e_op_i      = v.e;
        u_if.f_op_i      = v.f;
        u_if.isZ_op_i    = v.cls[3];
        u_if.isInf_op_i  = v.cls[2];
        u_if.isSNAN_op_i = v.cls[1];
        u_if.isQNAN_op_i = v.cls[0];
    endtask

    task automatic scramble_ops();
        u_if.s_op_i      = 1'($urandom);
        u_if.e_op_i      = 8'($urandom);
        u_if.f_op_i      = 7'($urandom);
        u_if.isZ_op_i    = 1'($urandom);
        u_if.isInf_op_i  = 1'($urandom);
        u_if.isSNAN_op_i = 1'($urandom);
        u_if.isQNAN_op_i = 1'($urandom);
    endtask

    // Edges counted from the current point until valid_o is seen high (bounded)
    task automatic wait_valid(input bit scramble, output int edges);
        edges = 0;
        do begin
            if (scramble) scramble_ops();
            @(posedge clk); #1;
            edges++;
        end while (!u_if.valid_o && edges < 64);
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, " s_res"}, 32'(u_if.s_res_o), 32'd0);
        chk({tag, " e_res"}, 32'(u_if.e_res_o), 32'(v.xe));
        chk({tag, " f_res"}, 32'(u_if.f_res_o), 32'(v.xf));
        chk({tag, " flags"},
            32'({u_if.isOverflow_o, u_if.isUnderflow_o, u_if.isToRound_o}), 32'(v.xflg));
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit scramble);
        int lat;
        @(negedge clk);
        drive(v);
        u_if.doExp_i = 1'b1;
        @(posedge clk); #1;
        u_if.doExp_i = 1'b0;
        wait_valid(scramble, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat(v)));
        chk_result(tag, v);
        @(posedge clk); #1;
        chk({tag, " valid width"}, 32'(u_if.valid_o), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   g;
        int   pulses;
        vec_t vb;

        //            s  e     f      cls   xe    xf     flg   lat early
        vecs.push_back(mk(0, 127, 7'h00, 4'h0, 128, 7'h00, 3'b000, 15, 3));  // +1.0
        vecs.push_back(mk(1, 127, 7'h00, 4'h0, 126, 7'h00, 3'b000, 15, 3));  // -1.0
        vecs.push_back(mk(1, 126, 7'h00, 4'h0, 126, 7'h35, 3'b000, 15, 4));  // -0.5
        vecs.push_back(mk(0, 126, 7'h00, 4'h0, 127, 7'h35, 3'b000, 15, 4));  // +0.5
        vecs.push_back(mk(0, 126, 7'h40, 4'h0, 127, 7'h57, 3'b000, 15, 5));  // +0.75
        vecs.push_back(mk(0, 124, 7'h00, 4'h0, 127, 7'h0B, 3'b001, 15, 6));  // +0.125, round
        vecs.push_back(mk(0, 115, 7'h00, 4'h0, 127, 7'h00, 3'b000, 15, 15)); // 2^-12
        vecs.push_back(mk(0, 114, 7'h00, 4'h0, 127, 7'h00, 3'b000, 2, 2));   // 2^-13
        vecs.push_back(mk(0, 107, 7'h00, 4'h0, 127, 7'h00, 3'b000, 2, 2));   // 2^-20
        vecs.push_back(mk(0, 134, 7'h48, 4'h0, 255, 7'h00, 3'b100, 2, 2));   // +200
        vecs.push_back(mk(1, 134, 7'h48, 4'h0, 0,   7'h00, 3'b010, 2, 2));   // -200
        vecs.push_back(mk(0, 133, 7'h7E, 4'h0, 254, 7'h00, 3'b000, 15, 3));  // +127
        vecs.push_back(mk(1, 133, 7'h7C, 4'h0, 1,   7'h00, 3'b000, 15, 3));  // -126
        vecs.push_back(mk(1, 133, 7'h7D, 4'h0, 0,   7'h00, 3'b010, 2, 2));   // -126.5
        vecs.push_back(mk(0, 255, 7'h01, 4'h2, 255, 7'h40, 3'b000, 2, 2));   // SNAN
        vecs.push_back(mk(1, 255, 7'h40, 4'h1, 255, 7'h40, 3'b000, 2, 2));   // QNAN
        vecs.push_back(mk(1, 255, 7'h00, 4'h4, 0,   7'h00, 3'b000, 2, 2));   // -Inf
        vecs.push_back(mk(0, 255, 7'h00, 4'h4, 255, 7'h00, 3'b000, 2, 2));   // +Inf
        vecs.push_back(mk(0, 0,   7'h00, 4'h8, 127, 7'h00, 3'b000, 2, 2));   // zero

        rst = 1'b1;
        u_if.doExp_i = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'({u_if.s_res_o, u_if.e_res_o, u_if.f_res_o, u_if.valid_o,
                                  u_if.isOverflow_o, u_if.isUnderflow_o, u_if.isToRound_o}),
            32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

        // doExp_i held high: results every latency+1 edges
        vb = vecs[3];
        @(negedge clk);
        drive(vb);
        u_if.doExp_i = 1'b1;
        @(posedge clk); #1;
        wait_valid(1'b0, g);
        chk("hold first latency", 32'(g), 32'(exp_lat(vb)));
        chk_result("hold first", vb);
        for (int p = 0; p < 2; p++) begin
            wait_valid(1'b0, g);
            chk($sformatf("hold gap%0d", p), 32'(g), 32'(exp_lat(vb) + 1));
            chk_result($sformatf("hold pulse%0d", p), vb);
        end
        u_if.doExp_i = 1'b0;
        repeat (20) @(posedge clk);

        // Operand inputs toggled while busy; results then hold through idle cycles
        run_vec("busy toggle", vecs[4], 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_result("hold after done", vecs[4]);

        // Reset in the middle of ITER aborts the operation
        @(negedge clk);
        drive(vecs[6]);
        u_if.doExp_i = 1'b1;
        @(posedge clk); #1;
        u_if.doExp_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort outputs", 32'({u_if.s_res_o, u_if.e_res_o, u_if.f_res_o, u_if.valid_o,
                                  u_if.isOverflow_o, u_if.isUnderflow_o, u_if.isToRound_o}),
            32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (u_if.valid_o) pulses++;
        end
        chk("abort no valid", 32'(pulses), 32'd0);
        run_vec("after abort", vecs[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
